count_seq_checker: RTL and testbench

//  Receive-side checker for the free-running binary counter stream that test_design produces.

---
 rtl/cnt_chk_pkg.sv | 16 +
 rtl/sat_counter.sv | 41 ++++
 rtl/count_seq_checker.sv | 134 +++++++++++++
 tb/tb_count_seq_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// Shared definitions for the counter-stream checker.
//   state_e      : checker FSM states (2-bit encoding, HUNT is the reset state)
//   DEF_LOCK_CNT : default number of consecutive correct increments needed to lock
//   DEF_MISS_MAX : default number of consecutive misses in LOCK that drop lock
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'b00,
        SYNC = 2'b01,
        LOCK = 2'b10
    } state_e;

    localparam int DEF_LOCK_CNT = 3;
    localparam int DEF_MISS_MAX = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears the count
//   clr_i   : synchronous clear
//   inc_i   : increment request
//   count_o : current count; sticks at all-ones, never wraps
// When clr_i and inc_i arrive together the count becomes 1, so the event
// that coincides with the clear is still counted.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running binary counter stream.
// Locks onto the +1 (mod 2^WIDTH) sequence and reports mismatches.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset (release assumed synchronised upstream)
//   in_valid  : in_count is sampled this cycle; when low nothing changes
//   in_count  : observed counter value
//   clr_err   : synchronous clear of err_count
//   locked    : high while the FSM is in LOCK
//   err_pulse : one-cycle pulse per mismatch seen in LOCK
//   lost_lock : one-cycle pulse on the LOCK->HUNT transition
//   err_count : saturating count of err_pulse events
//   expected  : next value the checker expects
//   dbg_state : raw FSM state (state_e encoding) for observation
// Handshake: there is no back-pressure; a sample is consumed on every rising
// edge where in_valid is high, and every output reflects that sample right
// after the same edge.
module count_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int MISS_MAX = DEF_MISS_MAX,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             lost_lock,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       dbg_state
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(MISS_MAX + 1);

    state_e            state_q,     state_d;
    logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
    logic [MS_W-1:0]   miss_cnt_q,  miss_cnt_d;
    logic [WIDTH-1:0]  expected_q,  expected_d;
    logic              err_pulse_q, err_pulse_d;
    logic              lost_lock_q, lost_lock_d;
    logic              is_match;

    assign is_match = (in_count == expected_q);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        expected_d  = expected_q;
        err_pulse_d = 1'b0;
        lost_lock_d = 1'b0;
        if (in_valid) begin
            // Every sample, good or bad, re-seeds the prediction.
            expected_d = in_count + 1'b1;
            case (state_q)
                HUNT: begin
                    match_cnt_d = '0;
                    state_d     = SYNC;
                end
                SYNC: begin
                    if (is_match) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
                            state_d    = LOCK;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCK: begin
                    if (is_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (miss_cnt_q == MS_W'(MISS_MAX - 1)) begin
                            lost_lock_d = 1'b1;
                            miss_cnt_d  = '0;
                            state_d     = HUNT;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            expected_q  <= '0;
            err_pulse_q <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            expected_q  <= expected_d;
            err_pulse_q <= err_pulse_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    // Fed with the same-cycle error decision so err_count and err_pulse
    // update on the same edge.
    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (clr_err),
        .inc_i   (err_pulse_d),
        .count_o (err_count)
    );

    assign locked    = (state_q == LOCK);
    assign err_pulse = err_pulse_q;
    assign lost_lock = lost_lock_q;
    assign expected  = expected_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

  // observation word: {locked, err_pulse, lost_lock, err_count[7:0], expected[3:0]}
  localparam int OW = 15;

  typedef struct {
    logic          valid;
    logic [3:0]    cnt;
    logic          clr;
    logic [OW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_cnt = '0, b_cnt = '0;
  logic       a_clr = 1'b0, b_clr = 1'b0;

  logic       a_locked, a_pulse, a_lost, b_locked, b_pulse, b_lost;
  logic [7:0] a_errc, b_errc;
  logic [3:0] a_exp, b_exp;
  logic [1:0] a_state, b_state;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q[$];
  vec_t vecs[$];

  count_seq_checker u_dut (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_count(a_cnt), .clr_err(a_clr),
    .locked(a_locked), .err_pulse(a_pulse), .lost_lock(a_lost),
    .err_count(a_errc), .expected(a_exp), .dbg_state(a_state)
  );

  // same design with a huge miss budget so errors can pile up without losing lock
  count_seq_checker #(.MISS_MAX(1000)) u_sat (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_count(b_cnt), .clr_err(b_clr),
    .locked(b_locked), .err_pulse(b_pulse), .lost_lock(b_lost),
    .err_count(b_errc), .expected(b_exp), .dbg_state(b_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] pk(input logic l, input logic p, input logic ll,
                                       input logic [7:0] ec, input logic [3:0] ex);
    return {l, p, ll, ec, ex};
  endfunction

  function automatic logic [OW-1:0] obs(input int sel);
    if (sel == 0) return {a_locked, a_pulse, a_lost, a_errc, a_exp};
    return {b_locked, b_pulse, b_lost, b_errc, b_exp};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got l=%b p=%b ll=%b ec=%0d ex=%0d, want l=%b p=%b ll=%b ec=%0d ex=%0d",
               name, got[14], got[13], got[12], got[11:4], got[3:0],
               want[14], want[13], want[12], want[11:4], want[3:0]);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: state got %0d want %0d", name, got, want);
    end
  endtask

  task automatic add(input logic v, input int c, input logic clr, input logic l,
                     input logic p, input logic ll, input int ec, input int ex);
    vec_t t;
    t.valid = v;
    t.cnt   = 4'(c);
    t.clr   = clr;
    t.exp   = pk(l, p, ll, 8'(ec), 4'(ex));
    vecs.push_back(t);
  endtask

  // driver: inputs at negedge, expected pushed, DUT result popped #1 after posedge
  task automatic apply(input int sel, input vec_t v, input string name);
    logic [OW-1:0] want;
    @(negedge clk);
    if (sel == 0) begin
      a_valid = v.valid; a_cnt = v.cnt; a_clr = v.clr;
    end else begin
      b_valid = v.valid; b_cnt = v.cnt; b_clr = v.clr;
    end
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(name, obs(sel), want);
    a_valid = 1'b0; a_clr = 1'b0;
    b_valid = 1'b0; b_clr = 1'b0;
  endtask

  initial begin
    vec_t t;
    int k;

    // ---- table: clean stream 0..15,0 with wrap ----
    for (int i = 0; i <= 16; i++) add(1, i % 16, 0, (i >= 3), 0, 0, 0, (i + 1) % 16);
    for (int i = 1; i <= 4; i++)  add(1, i, 0, 1, 0, 0, 0, i + 1);
    // single injected error: 7 instead of 5, then 8,9
    add(1, 7, 0, 1, 1, 0, 1, 8);
    add(1, 8, 0, 1, 0, 0, 1, 9);
    add(1, 9, 0, 1, 0, 0, 1, 10);
    // advance to expected 3
    for (int i = 10; i <= 18; i++) add(1, i % 16, 0, 1, 0, 0, 1, (i + 1) % 16);
    // two consecutive misses -> lost lock
    add(1, 3,  0, 1, 0, 0, 1, 4);
    add(1, 9,  0, 1, 1, 0, 2, 10);
    add(1, 12, 0, 0, 1, 1, 3, 13);
    // relock: capture plus three correct
    add(1, 13, 0, 0, 0, 0, 3, 14);
    add(1, 14, 0, 0, 0, 0, 3, 15);
    add(1, 15, 0, 0, 0, 0, 3, 0);
    add(1, 0,  0, 1, 0, 0, 3, 1);
    // in_valid low with junk data: everything holds
    for (int i = 0; i < 5; i++) add(0, $urandom_range(0, 15), 0, 1, 0, 0, 3, 1);
    add(1, 1, 0, 1, 0, 0, 3, 2);
    // clear without and with coincident error
    add(1, 2,  1, 1, 0, 0, 0, 3);
    add(1, 9,  1, 1, 1, 0, 1, 10);
    add(1, 10, 0, 1, 0, 0, 1, 11);
    // isolated misses separated by a match do not drop lock
    add(1, 5, 0, 1, 1, 0, 2, 6);
    add(1, 6, 0, 1, 0, 0, 2, 7);
    add(1, 0, 0, 1, 1, 0, 3, 1);
    add(1, 0, 0, 0, 1, 1, 4, 1);
    // SYNC mismatch: recapture, no error
    add(1, 5, 0, 0, 0, 0, 4, 6);
    add(1, 6, 0, 0, 0, 0, 4, 7);
    add(1, 2, 0, 0, 0, 0, 4, 3);
    add(1, 3, 0, 0, 0, 0, 4, 4);
    add(1, 4, 0, 0, 0, 0, 4, 5);
    add(1, 5, 0, 1, 0, 0, 4, 6);

    // ---- reset ----
    #12;
    check("reset_a", obs(0), '0);
    check("reset_b", obs(1), '0);
    check_state("reset_state", a_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) apply(0, vecs[i], $sformatf("vec%0d", i));

    // ---- async reset mid-LOCK, between edges ----
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outputs", obs(0), '0);
    check_state("async_rst_state", a_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    t.valid = 1; t.cnt = 4'd6; t.clr = 0; t.exp = pk(0, 0, 0, 8'd0, 4'd7);
    apply(0, t, "post_rst_capture");
    check_state("post_rst_sync", a_state, 2'd1);

    // ---- saturation on the large-MISS_MAX instance ----
    for (int i = 0; i < 4; i++) begin
      t.valid = 1; t.cnt = 4'(i); t.clr = 0; t.exp = pk((i == 3), 0, 0, 8'd0, 4'(i + 1));
      apply(1, t, $sformatf("sat_lock%0d", i));
    end
    for (int i = 1; i <= 300; i++) begin
      k = (i > 255) ? 255 : i;
      t.valid = 1; t.cnt = 4'd5; t.clr = 0; t.exp = pk(1, 1, 0, 8'(k), 4'd6);
      apply(1, t, $sformatf("sat_err%0d", i));
    end
    t.valid = 1; t.cnt = 4'd5; t.clr = 1; t.exp = pk(1, 1, 0, 8'd1, 4'd6);
    apply(1, t, "sat_clr_with_err");
    t.valid = 1; t.cnt = 4'd6; t.clr = 1; t.exp = pk(1, 0, 0, 8'd0, 4'd7);
    apply(1, t, "sat_clr_plain");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
